// File: rtl/gf180mcu_fd_sc_mcu9t5v0__rrarb3_pkg.sv
// Shared types and constants for the rrarb3 round-robin arbiter cell model.
// The optional GF180MCU_FD_SC_RRARB_TIMEOUT_EN build adds a grant hold limit.
package gf180mcu_fd_sc_rrarb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  localparam int N_REQ_DEF    = 3;
  localparam int HOLD_MAX_DEF = 15;

  // A single requester still needs a 1-bit pointer register.
  function automatic int ptr_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__rrarb3_if.sv
// Request/grant bundle between requesters (master) and the arbiter (slave).
// Timeout build option GF180MCU_FD_SC_RRARB_TIMEOUT_EN does not change this bundle.
interface gf180mcu_fd_sc_mcu9t5v0__rrarb3_if #(
  parameter int N_REQ = 3
);
  logic [N_REQ-1:0] REQ;
  logic             DONE;
  logic [N_REQ-1:0] GNT;
  logic             BUSY;

  modport master (output REQ, DONE, input  GNT, BUSY);
  modport slave  (input  REQ, DONE, output GNT, BUSY);
endinterface

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__rrarb3_func.sv
// Flat-port functional wrapper matching the cell library delivery format.
// Honours GF180MCU_FD_SC_RRARB_TIMEOUT_EN through the wrapped arbiter.
module gf180mcu_fd_sc_mcu9t5v0__rrarb3_func
  import gf180mcu_fd_sc_rrarb_pkg::*;
#(
  parameter int N_REQ    = N_REQ_DEF,
  parameter int HOLD_MAX = HOLD_MAX_DEF
) (
  input  logic             CLK,
  input  logic             RN,
  input  logic [N_REQ-1:0] REQ,
  input  logic             DONE,
  output logic [N_REQ-1:0] GNT,
  output logic             BUSY
);

  gf180mcu_fd_sc_mcu9t5v0__rrarb3_if #(.N_REQ(N_REQ)) u_bus ();

  assign u_bus.REQ  = REQ;
  assign u_bus.DONE = DONE;
  assign GNT        = u_bus.GNT;
  assign BUSY       = u_bus.BUSY;

  gf180mcu_fd_sc_mcu9t5v0__rrarb3 #(.N_REQ(N_REQ), .HOLD_MAX(HOLD_MAX)) u_arb (
    .CLK (CLK),
    .RN  (RN),
    .bus (u_bus)
  );

endmodule

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__rrarb3_pick.sv
// Combinational rotate-priority picker: first set request at or after ptr, wrapping.
// Identical in both GF180MCU_FD_SC_RRARB_TIMEOUT_EN builds.
module gf180mcu_fd_sc_mcu9t5v0__rrarb3_pick
  import gf180mcu_fd_sc_rrarb_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int PW    = ptr_w(N_REQ)
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [PW-1:0]    i_ptr,
  output logic [N_REQ-1:0] o_sel,
  output logic [PW-1:0]    o_idx,
  output logic             o_any
);

  logic w_found;

  always_comb begin
    o_sel   = '0;
    o_idx   = '0;
    o_any   = |i_req;
    w_found = 1'b0;
    // Modulo wrap also tolerates an out-of-range pointer value.
    for (int k = 0; k < N_REQ; k++) begin
      if (!w_found && i_req[(int'(i_ptr) + k) % N_REQ]) begin
        w_found = 1'b1;
        o_sel[(int'(i_ptr) + k) % N_REQ] = 1'b1;
        o_idx = PW'((int'(i_ptr) + k) % N_REQ);
      end
    end
  end

endmodule

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__rrarb3.sv
// Round-robin arbiter: registered one-hot grant held until DONE/abandon, one dead cycle between grants.
// Define GF180MCU_FD_SC_RRARB_TIMEOUT_EN to force release after HOLD_MAX grant cycles.
module gf180mcu_fd_sc_mcu9t5v0__rrarb3
  import gf180mcu_fd_sc_rrarb_pkg::*;
#(
  parameter int N_REQ    = N_REQ_DEF,
  parameter int HOLD_MAX = HOLD_MAX_DEF
) (
  input  logic CLK,
  input  logic RN,
  gf180mcu_fd_sc_mcu9t5v0__rrarb3_if.slave bus
);

  localparam int PW = ptr_w(N_REQ);

  state_e           r_state, w_state_nxt;
  logic [PW-1:0]    r_ptr,   w_ptr_nxt;
  logic [N_REQ-1:0] r_gnt,   w_gnt_nxt;
  logic             r_busy,  w_busy_nxt;

  logic [N_REQ-1:0] w_sel;
  logic [PW-1:0]    w_idx, w_idx_inc;
  logic             w_any, w_tmo, w_rel;

  gf180mcu_fd_sc_mcu9t5v0__rrarb3_pick #(.N_REQ(N_REQ), .PW(PW)) u_pick (
    .i_req (bus.REQ),
    .i_ptr (r_ptr),
    .o_sel (w_sel),
    .o_idx (w_idx),
    .o_any (w_any)
  );

  assign w_idx_inc = (w_idx == PW'(N_REQ - 1)) ? '0 : w_idx + PW'(1);

`ifdef GF180MCU_FD_SC_RRARB_TIMEOUT_EN
  localparam int HW = $clog2(HOLD_MAX + 1);
  logic [HW-1:0] r_hold, w_hold_nxt;

  assign w_tmo = (r_hold == HW'(HOLD_MAX - 1));

  // Zero on every IDLE cycle, so it is already clear on the entry edge.
  always_comb begin
    w_hold_nxt = '0;
    if (r_state == GRANT) w_hold_nxt = r_hold + HW'(1);
  end

  always_ff @(posedge CLK) begin
    if (!RN) r_hold <= '0;
    else     r_hold <= w_hold_nxt;
  end
`else
  // Untimed build: grants end only on DONE or abandon; HOLD_MAX has no effect.
  assign w_tmo = 1'b0 & (HOLD_MAX != 0);
`endif

  // Owner still requesting iff its REQ bit overlaps the held grant.
  assign w_rel = bus.DONE | ~|(bus.REQ & r_gnt) | w_tmo;

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_gnt_nxt   = r_gnt;
    w_busy_nxt  = r_busy;
    case (r_state)
      IDLE: begin
        if (w_any) begin
          w_state_nxt = GRANT;
          w_gnt_nxt   = w_sel;
          w_busy_nxt  = 1'b1;
          w_ptr_nxt   = w_idx_inc;
        end
      end
      GRANT: begin
        if (w_rel) begin
          w_state_nxt = IDLE;
          w_gnt_nxt   = '0;
          w_busy_nxt  = 1'b0;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_gnt_nxt   = '0;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RN) begin
      r_state <= IDLE;
      r_ptr   <= '0;
      r_gnt   <= '0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_gnt   <= w_gnt_nxt;
      r_busy  <= w_busy_nxt;
    end
  end

  assign bus.GNT  = r_gnt;
  assign bus.BUSY = r_busy;

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu9t5v0__rrarb3.sv
// Directed plus random bench for rrarb3 against a queue-free owner/pointer reference model.
// Define GF180MCU_FD_SC_RRARB_TIMEOUT_EN to exercise the hold limit with HOLD_MAX=4.
module tb_gf180mcu_fd_sc_mcu9t5v0__rrarb3;

  localparam int N = 3;
`ifdef GF180MCU_FD_SC_RRARB_TIMEOUT_EN
  localparam int HM  = 4;
  localparam bit TMO = 1'b1;
`else
  localparam int HM  = 15;
  localparam bit TMO = 1'b0;
`endif

  logic CLK = 1'b0;
  logic RN;
  always #5 CLK = ~CLK;

  gf180mcu_fd_sc_mcu9t5v0__rrarb3_if #(.N_REQ(N)) bus ();

  gf180mcu_fd_sc_mcu9t5v0__rrarb3 #(.N_REQ(N), .HOLD_MAX(HM)) u_dut (
    .CLK (CLK),
    .RN  (RN),
    .bus (bus)
  );

  int m_own  = -1;
  int m_ptr  = 0;
  int m_held = 0;
  int total  = 0;
  int bad    = 0;

  task automatic step(input logic [N-1:0] r, input logic d, input logic rn, input string tag);
    logic [N-1:0] e_gnt;
    logic         e_busy;
    bus.REQ  = r;
    bus.DONE = d;
    RN       = rn;
    @(posedge CLK);
    if (!rn) begin
      m_own = -1; m_ptr = 0; m_held = 0;
    end else if (m_own < 0) begin
      if (r != '0) begin
        for (int k = 0; k < N; k++) begin
          if (r[(m_ptr + k) % N]) begin
            m_own = (m_ptr + k) % N;
            break;
          end
        end
        m_ptr  = (m_own + 1) % N;
        m_held = 1;
      end
    end else if (d || !r[m_own] || (TMO && m_held >= HM)) begin
      m_own = -1;
    end else begin
      m_held++;
    end
    e_gnt = '0;
    if (m_own >= 0) e_gnt[m_own] = 1'b1;
    e_busy = (m_own >= 0);
    #1;
    total++;
    assert (bus.GNT === e_gnt) else begin
      bad++;
      $error("FAIL %s gnt got=%b exp=%b", tag, bus.GNT, e_gnt);
    end
    total++;
    assert (bus.BUSY === e_busy) else begin
      bad++;
      $error("FAIL %s busy got=%b exp=%b", tag, bus.BUSY, e_busy);
    end
  endtask

  initial begin
    bus.REQ = '0; bus.DONE = 1'b0; RN = 1'b0;
    // reset with all requesting
    step(3'b111, 1'b0, 1'b0, "rst0");
    step(3'b111, 1'b0, 1'b0, "rst1");
    step(3'b111, 1'b0, 1'b1, "rst_first");
    // rotation with DONE pulses
    step(3'b111, 1'b1, 1'b1, "rot_rel0");
    step(3'b111, 1'b0, 1'b1, "rot_g1");
    step(3'b111, 1'b1, 1'b1, "rot_rel1");
    step(3'b111, 1'b0, 1'b1, "rot_g2");
    step(3'b111, 1'b1, 1'b1, "rot_rel2");
    step(3'b111, 1'b0, 1'b1, "rot_wrap");
    // abandon by owner 1
    step(3'b111, 1'b1, 1'b1, "ab_rel");
    step(3'b111, 1'b0, 1'b1, "ab_g1");
    step(3'b101, 1'b0, 1'b1, "ab_drop");
    step(3'b101, 1'b0, 1'b1, "ab_g2");
    // mid-grant reset
    step(3'b101, 1'b1, 1'b1, "mr_rel");
    step(3'b010, 1'b0, 1'b1, "mr_g1");
    step(3'b010, 1'b0, 1'b0, "mr_rst");
    step(3'b010, 1'b0, 1'b1, "mr_regrant");
    // DONE while owner keeps requesting
    step(3'b010, 1'b1, 1'b1, "sd_rel");
    step(3'b001, 1'b0, 1'b1, "sd_g0");
    step(3'b001, 1'b1, 1'b1, "sd_done");
    step(3'b001, 1'b0, 1'b1, "sd_again");
    step(3'b001, 1'b0, 1'b1, "sd_hold");
    // DONE in IDLE is ignored
    step(3'b000, 1'b1, 1'b1, "idle_done0");
    step(3'b000, 1'b1, 1'b1, "idle_done1");
    // long hold: timeout or indefinite grant
    step(3'b000, 1'b0, 1'b0, "to_rst");
    repeat (100) step(3'b011, 1'b0, 1'b1, "long_hold");
    // random traffic
    repeat (600) begin
      step(N'($urandom_range(0, 7)), ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 40) != 0), "rand");
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
